// File: rtl/temp_fmt_pkg.sv
// temp_fmt_pkg: FSM states, ASCII constants and clamp limits shared by the temperature formatter
package temp_fmt_pkg;
  typedef enum logic [1:0] {IDLE, LATCH, CONV, SEND} state_t;
  localparam logic [7:0] PLUS   = 8'h2B;
  localparam logic [7:0] MINUS  = 8'h2D;
  localparam logic [7:0] DOT    = 8'h2E;
  localparam logic [7:0] SPACE  = 8'h20;
  localparam logic [7:0] CHAR_C = 8'h43;
  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] LF     = 8'h0A;
  localparam logic [7:0] ZERO   = 8'h30;
  localparam logic [9:0] INT_MAX  = 10'd999;
  localparam logic [6:0] FRAC_MAX = 7'd99;
  function automatic logic [7:0] asc(input logic [3:0] d);
    return ZERO | {4'h0, d};
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one shift-add-3 step per clock
// Ports: clk, rst (async, high), start loads bin; busy while shifting;
//        done holds high from completion until the next start; bcd = DIGITS packed BCD digits.
module bin2bcd_seq #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(BIN_W + 1);
  logic [BIN_W-1:0]    sh_q;
  logic [4*DIGITS-1:0] bcd_q, adj;
  logic [CW-1:0]       cnt_q;
  logic                busy_q, done_q;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      sh_q   <= bin;
      bcd_q  <= '0;
      cnt_q  <= CW'(BIN_W);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      {bcd_q, sh_q} <= {adj[4*DIGITS-2:0], sh_q, 1'b0};
      cnt_q         <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
endmodule

// File: rtl/temp_ascii_fmt.sv
// temp_ascii_fmt: converts a signed fixed-point temperature to an ASCII line streamed over valid/ready
// Ports: clk, rst (async, high); start + temp_raw request a conversion; busy outside IDLE;
//        out_data/out_valid/out_ready byte stream; done pulses after the last byte; sat flags clamping.
// Optional macro TEMP_FMT_UNIT_EN appends " C" after the fraction digits.
module temp_ascii_fmt
  import temp_fmt_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 4,
  parameter int SEND_CRLF  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] temp_raw,
  output logic                  busy,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  sat
);
`ifdef TEMP_FMT_UNIT_EN
  localparam int UNIT_N = 2;
`else
  localparam int UNIT_N = 0;
`endif
  localparam int         NBYTES = 7 + UNIT_N + (SEND_CRLF != 0 ? 2 : 0);
  localparam logic [3:0] LAST   = 4'(NBYTES - 1);
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] raw_q, raw_d;
  logic                  sign_q, sign_d, sat_q, sat_d, done_q, done_d, valid_q, valid_d;
  logic [7:0]            data_q, data_d;
  logic [3:0]            idx_q, idx_d, sel;
  logic [DATA_WIDTH:0]   ext, mag, int_full;
  logic [FRAC_BITS+6:0]  fprod;
  logic                  over, conv_go, int_busy, int_done, frac_busy, frac_done;
  logic [9:0]            int_v;
  logic [6:0]            frac_v;
  logic [11:0]           int_bcd;
  logic [7:0]            frac_bcd, nxt_byte;
  logic [7:0]            frame [16];
  // one extra bit so the most negative code still has a representable magnitude
  assign ext      = {raw_q[DATA_WIDTH-1], raw_q};
  assign mag      = ext[DATA_WIDTH] ? -ext : ext;
  assign int_full = mag >> FRAC_BITS;
  assign fprod    = (FRAC_BITS+7)'(mag[FRAC_BITS-1:0]) * (FRAC_BITS+7)'(7'd100);
  assign over     = int_full > (DATA_WIDTH+1)'(INT_MAX);
  assign int_v    = over ? INT_MAX : 10'(int_full);
  assign frac_v   = over ? FRAC_MAX : 7'(fprod >> FRAC_BITS);
  assign conv_go  = state_q == LATCH;
  bin2bcd_seq #(.BIN_W(10), .DIGITS(3)) u_int (
    .clk(clk), .rst(rst), .start(conv_go), .bin(int_v),
    .busy(int_busy), .done(int_done), .bcd(int_bcd)
  );
  bin2bcd_seq #(.BIN_W(7), .DIGITS(2)) u_frac (
    .clk(clk), .rst(rst), .start(conv_go), .bin(frac_v),
    .busy(frac_busy), .done(frac_done), .bcd(frac_bcd)
  );
  always_comb begin
    for (int k = 0; k < 16; k++) frame[k] = 8'h00;
    frame[0] = sign_q ? MINUS : PLUS;
    frame[1] = asc(int_bcd[11:8]);
    frame[2] = asc(int_bcd[7:4]);
    frame[3] = asc(int_bcd[3:0]);
    frame[4] = DOT;
    frame[5] = asc(frac_bcd[7:4]);
    frame[6] = asc(frac_bcd[3:0]);
`ifdef TEMP_FMT_UNIT_EN
    frame[7] = SPACE;
    frame[8] = CHAR_C;
`endif
    if (SEND_CRLF != 0) begin
      frame[7+UNIT_N] = CR;
      frame[8+UNIT_N] = LF;
    end
  end
  // in SEND the mux looks one byte ahead so the next byte is ready on the transfer edge
  assign sel      = state_q == SEND ? idx_q + 4'd1 : 4'd0;
  assign nxt_byte = frame[sel];
  always_comb begin
    state_d = state_q;
    raw_d   = raw_q;
    sign_d  = sign_q;
    sat_d   = sat_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        raw_d   = temp_raw;
        state_d = LATCH;
      end
      LATCH: begin
        sign_d  = raw_q[DATA_WIDTH-1];
        sat_d   = over;
        state_d = CONV;
      end
      CONV: if (int_done && frac_done && !int_busy && !frac_busy) begin
        state_d = SEND;
        idx_d   = 4'd0;
        valid_d = 1'b1;
        data_d  = nxt_byte;
      end
      SEND: if (out_ready) begin
        if (idx_q == LAST) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d  = idx_q + 4'd1;
          data_d = nxt_byte;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      raw_q   <= '0;
      sign_q  <= 1'b0;
      sat_q   <= 1'b0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raw_q   <= raw_d;
      sign_q  <= sign_d;
      sat_q   <= sat_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign done      = done_q;
  assign sat       = sat_q;
endmodule

// File: tb/tb_temp_ascii_fmt.sv
// tb_temp_ascii_fmt: table-driven checks of the ASCII temperature formatter
module tb_temp_ascii_fmt;
  localparam int CRLF = 1;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [15:0] temp_raw = '0;
  logic        busy, out_valid, done, sat;
  logic [7:0]  out_data;
  int          n_cmp = 0, n_bad = 0;
  logic [7:0]  exp_q[$];

  temp_ascii_fmt #(.DATA_WIDTH(16), .FRAC_BITS(4), .SEND_CRLF(CRLF)) dut (
    .clk(clk), .rst(rst), .start(start), .temp_raw(temp_raw), .busy(busy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .done(done), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] raw;
    int          ip;
    int          fp;
    bit          neg;
    bit          s;
    int          rmode;
  } vec_t;
  vec_t v[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  function automatic void build(input int ip, input int fp, input bit neg);
    exp_q.delete();
    exp_q.push_back(neg ? 8'h2D : 8'h2B);
    exp_q.push_back(8'(8'h30 + ip / 100));
    exp_q.push_back(8'(8'h30 + (ip / 10) % 10));
    exp_q.push_back(8'(8'h30 + ip % 10));
    exp_q.push_back(8'h2E);
    exp_q.push_back(8'(8'h30 + fp / 10));
    exp_q.push_back(8'(8'h30 + fp % 10));
`ifdef TEMP_FMT_UNIT_EN
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h43);
`endif
    if (CRLF != 0) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  // Runs one frame against exp_q. rmode 0: ready always high, 1: ready high ~1 cycle in 3.
  // inj >= 0 pulses a stray start at that edge count; chain issues the next start in the done cycle.
  task automatic run_frame(input logic [15:0] raw, input bit do_start, input int rmode, input int inj,
                           input bit chain, input logic [15:0] raw_next, input bit exp_sat);
    logic [7:0] got[$];
    int         e = 0, first = -1;
    logic       pv = 1'b0, pr = 1'b0, rdy, fin = 1'b0;
    logic [7:0] pd = '0;
    if (do_start) begin
      @(negedge clk);
      temp_raw = raw;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    temp_raw = 16'h5A5A;
    while (!fin && e < 400) begin
      if (pv && !pr) chk("stall_hold", {out_valid, out_data}, {1'b1, pd});
      if (out_valid && first < 0) first = e;
      start = (inj >= 0 && e == inj);
      if (start) temp_raw = 16'h07D0;
      rdy       = rmode == 0 ? 1'b1 : ($urandom_range(0, 2) == 0);
      out_ready = rdy;
      if (out_valid && rdy) begin
        got.push_back(out_data);
        if (got.size() == exp_q.size()) fin = 1'b1;
      end
      pv = out_valid;
      pr = rdy;
      pd = out_data;
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    chk("first_valid_edge", first, 12);
    chk("byte_count", got.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) chk($sformatf("byte%0d", k), got[k], exp_q[k]);
    chk("done_pulse", {done, out_valid, busy}, 3'b100);
    chk("sat", sat, exp_sat);
    out_ready = 1'b1;
    if (chain) begin
      temp_raw = raw_next;
      start    = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_clear", {done, busy}, {1'b0, chain});
  endtask

  initial begin
    v[0] = '{16'h0191,  25,  6, 1'b0, 1'b0, 0};
    v[1] = '{16'hFF5E,  10, 12, 1'b1, 1'b0, 0};
    v[2] = '{16'h0000,   0,  0, 1'b0, 1'b0, 0};
    v[3] = '{16'h7FFF, 999, 99, 1'b0, 1'b1, 0};
    v[4] = '{16'h07D0, 125,  0, 1'b0, 1'b0, 0};
    v[5] = '{16'hFFFF,   0,  6, 1'b1, 1'b0, 0};
    v[6] = '{16'h8000, 999, 99, 1'b1, 1'b1, 0};
    v[7] = '{16'h3E7F, 999, 93, 1'b0, 1'b0, 1};
    v[8] = '{16'h3E80, 999, 99, 1'b0, 1'b1, 1};
    v[9] = '{16'h0191,  25,  6, 1'b0, 1'b0, 1};
    #1;
    chk("rst_outputs", {busy, out_valid, out_data, done, sat}, 12'h000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("idle_after_rst", {busy, out_valid, done}, 3'b000);
    for (int i = 0; i < 10; i++) begin
      build(v[i].ip, v[i].fp, v[i].neg);
      run_frame(v[i].raw, 1'b1, v[i].rmode, -1, 1'b0, 16'h0, v[i].s);
    end
    // stray start while busy is dropped, then a start in the done cycle is taken
    build(25, 6, 1'b0);
    run_frame(16'h0191, 1'b1, 0, 5, 1'b1, 16'hFF5E, 1'b0);
    build(10, 12, 1'b1);
    run_frame(16'hFF5E, 1'b0, 0, -1, 1'b0, 16'h0, 1'b0);
    repeat (20) @(negedge clk);
    chk("no_queued_frame", {busy, out_valid}, 2'b00);
    // reset in the middle of SEND abandons the frame immediately
    begin
      int n = 0, e = 0;
      temp_raw = 16'h0191;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (n < 4 && e < 100) begin
        if (out_valid) n++;
        @(negedge clk);
        e++;
      end
      chk("bytes_before_rst", n, 4);
      chk("busy_before_rst", {busy, out_valid}, 2'b11);
      rst = 1'b1;
      #1;
      chk("async_rst", {busy, out_valid, done, out_data}, 11'h000);
      @(negedge clk);
      rst = 1'b0;
    end
    build(125, 0, 1'b0);
    run_frame(16'h07D0, 1'b1, 0, -1, 1'b0, 16'h0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
